// File: rtl/hs_dpath_pkg.sv
// Shared types and helpers for the hs_dpath valid/ready CE controller.
//   perf_cnt_t : 32-bit performance counter type
//   occ_width  : bit width able to hold an occupancy count of 0..stages
package hs_dpath_pkg;

  typedef logic [31:0] perf_cnt_t;

  function automatic int unsigned occ_width(input int unsigned stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/hs_dpath_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk : clock
//   inc : count enable, ignored once the counter sits at all-ones
//   clr : synchronous clear, has priority over inc
//   cnt : registered count value
module hs_dpath_sat_cnt #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/hs_dpath_pipe_ce_ctrl.sv
// Valid/ready flow controller producing per-stage clock enables for a
// tapped-CE shift register of STAGES stages. One valid bit per stage; a stage
// loads whenever it is empty or its contents move on, so bubbles collapse.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   flush            : synchronous flush, drops all in-flight beats
//   in_valid/in_ready: upstream handshake (data on shift register din)
//   out_valid/out_ready: downstream handshake (data on last stage dout)
//   ce[STAGES]       : per-stage clock enables, ce[0] loads din
//   stage_valid[STAGES]: registered per-stage valid bits
//   occupancy        : registered count of valid stages
// Optional feature macro HS_DPATH_PIPE_CE_PERF_EN adds:
//   perf_stall_cnt   : saturating count of cycles with out_valid & !out_ready
//   perf_bubble_cnt  : saturating count of cycles with !out_valid & occupancy!=0
module hs_dpath_pipe_ce_ctrl
  import hs_dpath_pkg::*;
#(
  parameter int unsigned STAGES = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         ce          [STAGES],
  output logic                         stage_valid [STAGES],
  output logic [occ_width(STAGES)-1:0] occupancy
`ifdef HS_DPATH_PIPE_CE_PERF_EN
  ,
  output perf_cnt_t                    perf_stall_cnt,
  output perf_cnt_t                    perf_bubble_cnt
`endif
);

  localparam int unsigned OW = occ_width(STAGES);

  logic          r_valid [STAGES];
  logic [OW-1:0] r_occ;
  logic          w_rdy   [STAGES];
  logic          w_src   [STAGES];
  logic          w_in_xfer;
  logic          w_out_xfer;

  // Ready ripples from the output end back towards the input: a stage can
  // take new data if it is empty or anything downstream of it can move.
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_src_in
      assign w_src[g] = in_valid;
    end else begin : g_src_prev
      assign w_src[g] = r_valid[g-1];
    end

    if (g == STAGES - 1) begin : g_rdy_last
      assign w_rdy[g] = !r_valid[g] | out_ready;
    end else begin : g_rdy_mid
      assign w_rdy[g] = !r_valid[g] | w_rdy[g+1];
    end

    assign ce[g]          = w_rdy[g] & w_src[g] & !flush;
    assign stage_valid[g] = r_valid[g];
  end

  assign in_ready   = w_rdy[0] & !flush;
  assign out_valid  = r_valid[STAGES-1];
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        r_valid[i] <= 1'b0;
      end
      r_occ <= '0;
    end else begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        if (w_rdy[i]) begin
          r_valid[i] <= w_src[i];
        end
      end
      r_occ <= r_occ + OW'(w_in_xfer) - OW'(w_out_xfer);
    end
  end

  assign occupancy = r_occ;

`ifdef HS_DPATH_PIPE_CE_PERF_EN
  logic w_perf_clr;
  logic w_stall;
  logic w_bubble;

  assign w_perf_clr = rst | flush;
  assign w_stall    = out_valid & !out_ready;
  assign w_bubble   = !out_valid & (r_occ != '0);

  hs_dpath_sat_cnt #(.WIDTH(32)) u_stall_cnt (
    .clk (clk),
    .inc (w_stall),
    .clr (w_perf_clr),
    .cnt (perf_stall_cnt)
  );

  hs_dpath_sat_cnt #(.WIDTH(32)) u_bubble_cnt (
    .clk (clk),
    .inc (w_bubble),
    .clr (w_perf_clr),
    .cnt (perf_bubble_cnt)
  );
`endif

endmodule
